// File: rtl/aur_link_ctrl.sv
// Aurora link-management controller: reset sequencing, channel qualification,
// frame-boundary queue gating and relink on errors. Optional stats: AUR_LINK_STATS_EN.
module aur_link_ctrl #(
  parameter int RESET_CYCLES    = 16,
  parameter int UP_TIMEOUT      = 1048576,
  parameter int STABLE_CYCLES   = 256,
  parameter int SOFT_ERR_THRESH = 8,
  parameter int SOFT_ERR_WINDOW = 65536,
  parameter int DRAIN_MAX       = 4096,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lane_up,
  input  logic                 channel_up,
  input  logic                 hard_error,
  input  logic                 soft_error,
  input  logic                 frame_error,
  input  logic                 tx_in_frame,
  input  logic                 force_relink,
  input  logic                 clear_stats,
  output logic                 link_reset,
  output logic                 tx_enable,
  output logic                 rx_enable,
  output logic                 link_ok,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] relink_count,
  output logic [CNT_WIDTH-1:0] hard_err_count,
  output logic [CNT_WIDTH-1:0] soft_err_count,
  output logic [CNT_WIDTH-1:0] frame_err_count
);

  typedef enum logic [2:0] {
    ST_RST     = 3'd0,
    ST_WAIT_UP = 3'd1,
    ST_STABLE  = 3'd2,
    ST_RUN     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] tmr_r;
  logic [31:0] tmr_nxt_s;
  logic        relink_inc_s;
  logic [31:0] win_tmr_r;
  logic [31:0] win_soft_r;
  logic        up_s;
  logic        in_run_s;
  logic        run_entry_s;
  logic        win_exp_s;
  logic        soft_trip_s;

  assign up_s        = channel_up & lane_up;
  assign in_run_s    = (state_r == ST_RUN);
  assign run_entry_s = (state_nxt_s == ST_RUN) && !in_run_s;
  assign win_exp_s   = (win_tmr_r >= 32'(SOFT_ERR_WINDOW - 1));
  assign soft_trip_s = in_run_s && soft_error && (win_soft_r >= 32'(SOFT_ERR_THRESH - 1));
  assign state       = state_r;

  // Next-state, phase timer and relink-event decode.
  always_comb begin
    state_nxt_s  = state_r;
    tmr_nxt_s    = tmr_r + 32'd1;
    relink_inc_s = 1'b0;
    case (state_r)
      ST_RST: begin
        if (tmr_r >= 32'(RESET_CYCLES - 1)) begin
          state_nxt_s = ST_WAIT_UP;
          tmr_nxt_s   = 32'd0;
        end else begin
          state_nxt_s = ST_RST;
        end
      end
      ST_WAIT_UP: begin
        if (force_relink) begin
          state_nxt_s  = ST_RST;
          tmr_nxt_s    = 32'd0;
          relink_inc_s = 1'b1;
        end else if (up_s) begin
          state_nxt_s = ST_STABLE;
          tmr_nxt_s   = 32'd0;
        end else if (tmr_r >= 32'(UP_TIMEOUT - 1)) begin
          state_nxt_s  = ST_RST;
          tmr_nxt_s    = 32'd0;
          relink_inc_s = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT_UP;
        end
      end
      ST_STABLE: begin
        // A drop only requalifies; it is not counted as a relink.
        if (force_relink) begin
          state_nxt_s  = ST_RST;
          tmr_nxt_s    = 32'd0;
          relink_inc_s = 1'b1;
        end else if (!up_s) begin
          state_nxt_s = ST_WAIT_UP;
          tmr_nxt_s   = 32'd0;
        end else if (tmr_r >= 32'(STABLE_CYCLES - 1)) begin
          state_nxt_s = ST_RUN;
          tmr_nxt_s   = 32'd0;
        end else begin
          state_nxt_s = ST_STABLE;
        end
      end
      ST_RUN: begin
        tmr_nxt_s = tmr_r;
        if (hard_error) begin
          state_nxt_s = ST_DRAIN;
          tmr_nxt_s   = 32'd0;
        end else if (!channel_up) begin
          state_nxt_s = ST_DRAIN;
          tmr_nxt_s   = 32'd0;
        end else if (force_relink) begin
          state_nxt_s = ST_DRAIN;
          tmr_nxt_s   = 32'd0;
        end else if (soft_trip_s) begin
          state_nxt_s = ST_DRAIN;
          tmr_nxt_s   = 32'd0;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!tx_in_frame || (tmr_r >= 32'(DRAIN_MAX - 1))) begin
          state_nxt_s  = ST_RST;
          tmr_nxt_s    = 32'd0;
          relink_inc_s = 1'b1;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_RST;
        tmr_nxt_s   = 32'd0;
      end
    endcase
  end

  // State register and outputs registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_RST;
      tmr_r      <= 32'd0;
      link_reset <= 1'b1;
      tx_enable  <= 1'b0;
      rx_enable  <= 1'b0;
      link_ok    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tmr_r      <= tmr_nxt_s;
      link_reset <= (state_nxt_s == ST_RST);
      tx_enable  <= (state_nxt_s == ST_RUN);
      rx_enable  <= (state_nxt_s == ST_RUN);
      link_ok    <= (state_nxt_s == ST_RUN);
    end
  end

  // Soft-error window: free-running, restarted on RUN entry; only RUN errors count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_tmr_r  <= 32'd0;
      win_soft_r <= 32'd0;
    end else if (run_entry_s || win_exp_s) begin
      win_tmr_r  <= 32'd0;
      win_soft_r <= 32'd0;
    end else begin
      win_tmr_r  <= win_tmr_r + 32'd1;
      win_soft_r <= win_soft_r + {31'd0, (in_run_s & soft_error)};
    end
  end

`ifdef AUR_LINK_STATS_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    logic [CNT_WIDTH-1:0] r;
    if (en && (v != {CNT_WIDTH{1'b1}})) begin
      r = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Saturating statistics; clear wins over a coincident increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      relink_count    <= {CNT_WIDTH{1'b0}};
      hard_err_count  <= {CNT_WIDTH{1'b0}};
      soft_err_count  <= {CNT_WIDTH{1'b0}};
      frame_err_count <= {CNT_WIDTH{1'b0}};
    end else if (clear_stats) begin
      relink_count    <= {CNT_WIDTH{1'b0}};
      hard_err_count  <= {CNT_WIDTH{1'b0}};
      soft_err_count  <= {CNT_WIDTH{1'b0}};
      frame_err_count <= {CNT_WIDTH{1'b0}};
    end else begin
      relink_count    <= sat_inc(relink_count, relink_inc_s);
      hard_err_count  <= sat_inc(hard_err_count, hard_error);
      soft_err_count  <= sat_inc(soft_err_count, soft_error);
      frame_err_count <= sat_inc(frame_err_count, frame_error);
    end
  end
`else
  logic unused_stats_s;
  assign unused_stats_s  = ^{clear_stats, relink_inc_s, frame_error};
  assign relink_count    = {CNT_WIDTH{1'b0}};
  assign hard_err_count  = {CNT_WIDTH{1'b0}};
  assign soft_err_count  = {CNT_WIDTH{1'b0}};
  assign frame_err_count = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_aur_link_ctrl.sv
// Directed self-checking bench for aur_link_ctrl (short timeouts, 4-bit counters).
module tb_aur_link_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic lane_up = 1'b0, channel_up = 1'b0, hard_error = 1'b0, soft_error = 1'b0;
  logic frame_error = 1'b0, tx_in_frame = 1'b0, force_relink = 1'b0, clear_stats = 1'b0;
  logic link_reset, tx_enable, rx_enable, link_ok;
  logic [2:0] state;
  logic [CW-1:0] relink_count, hard_err_count, soft_err_count, frame_err_count;

  int n_cmp = 0, n_bad = 0;
  int e_relink = 0, e_hard = 0, e_soft = 0, e_frame = 0;
  int n;

  aur_link_ctrl #(
    .RESET_CYCLES(16), .UP_TIMEOUT(100), .STABLE_CYCLES(256), .SOFT_ERR_THRESH(8),
    .SOFT_ERR_WINDOW(1000), .DRAIN_MAX(64), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .lane_up(lane_up), .channel_up(channel_up),
    .hard_error(hard_error), .soft_error(soft_error), .frame_error(frame_error),
    .tx_in_frame(tx_in_frame), .force_relink(force_relink), .clear_stats(clear_stats),
    .link_reset(link_reset), .tx_enable(tx_enable), .rx_enable(rx_enable),
    .link_ok(link_ok), .state(state), .relink_count(relink_count),
    .hard_err_count(hard_err_count), .soft_err_count(soft_err_count),
    .frame_err_count(frame_err_count)
  );

  always #5 clk = ~clk;

  function automatic int cexp(input int v);
`ifdef AUR_LINK_STATS_EN
    return (v > 15) ? 15 : v;
`else
    return (v > 15) ? 0 : 0 * v;
`endif
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, input int budget, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (int'(state) != s && cnt < budget);
    if (int'(state) != s) check_eq("wait_state_timeout", int'(state), s);
  endtask

  task automatic check_stats(input string tag);
    check_eq({tag, "_relink"}, int'(relink_count), cexp(e_relink));
    check_eq({tag, "_hard"}, int'(hard_err_count), cexp(e_hard));
    check_eq({tag, "_soft"}, int'(soft_err_count), cexp(e_soft));
    check_eq({tag, "_frame"}, int'(frame_err_count), cexp(e_frame));
  endtask

  task automatic soft_pulse();
    soft_error = 1'b1; tick(); soft_error = 1'b0; tick();
    e_soft++;
  endtask

  task automatic clear_all();
    clear_stats = 1'b1; tick(); clear_stats = 1'b0;
    e_relink = 0; e_hard = 0; e_soft = 0; e_frame = 0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check_eq("rst_state", int'(state), 0);
    check_eq("rst_link_reset", int'(link_reset), 1);
    check_eq("rst_tx_enable", int'(tx_enable), 0);
    check_eq("rst_link_ok", int'(link_ok), 0);
    check_stats("rst");
    reset = 1'b0;

    // Bring-up: 16 reset cycles, up at cycle 20, RUN 256 cycles later
    wait_state(1, 50, n);
    check_eq("rst_len", n, 16);
    check_eq("waitup_link_reset", int'(link_reset), 0);
    repeat (4) tick();
    channel_up = 1'b1; lane_up = 1'b1;
    tick();
    check_eq("stable_entry", int'(state), 2);
    wait_state(3, 400, n);
    check_eq("stable_len", n, 256);
    check_eq("run_tx_enable", int'(tx_enable), 1);
    check_eq("run_rx_enable", int'(rx_enable), 1);
    check_eq("run_link_ok", int'(link_ok), 1);

    // Hard error with a frame in flight
    tx_in_frame = 1'b1; hard_error = 1'b1; tick(); hard_error = 1'b0; e_hard++;
    check_eq("hard_drain", int'(state), 4);
    check_eq("drain_tx_enable", int'(tx_enable), 0);
    check_eq("drain_rx_enable", int'(rx_enable), 0);
    check_eq("drain_link_ok", int'(link_ok), 0);
    repeat (10) tick();
    check_eq("drain_hold", int'(state), 4);
    tx_in_frame = 1'b0; tick(); e_relink++;
    check_eq("drain_exit", int'(state), 0);
    check_eq("drain_exit_link_reset", int'(link_reset), 1);
    check_stats("hard");
    wait_state(3, 400, n);
    check_eq("relink_bringup", n, 273);

    // Eight soft errors inside one window trip the link
    repeat (7) soft_pulse();
    check_eq("soft7_run", int'(state), 3);
    soft_error = 1'b1; tick(); soft_error = 1'b0; e_soft++;
    check_eq("soft8_drain", int'(state), 4);
    tick(); e_relink++;
    check_eq("soft8_rst", int'(state), 0);
    check_stats("soft8");
    wait_state(3, 400, n);
    check_eq("soft_bringup", n, 273);

    // 7 + window expiry + 7 stays in RUN
    clear_all();
    check_stats("clear1");
    repeat (7) soft_pulse();
    repeat (1000) tick();
    repeat (7) soft_pulse();
    check_eq("soft_window_run", int'(state), 3);
    check_stats("soft14");

    // Channel glitch during qualification
    channel_up = 1'b0; tick();
    check_eq("chdown_drain", int'(state), 4);
    tick(); e_relink++;
    check_eq("chdown_rst", int'(state), 0);
    wait_state(1, 50, n);
    check_eq("chdown_rst_len", n, 16);
    channel_up = 1'b1; tick();
    check_eq("glitch_stable", int'(state), 2);
    repeat (200) tick();
    check_eq("glitch_stable200", int'(state), 2);
    channel_up = 1'b0; tick(); channel_up = 1'b1;
    check_eq("glitch_waitup", int'(state), 1);
    check_stats("glitch");
    tick();
    check_eq("glitch_restable", int'(state), 2);
    wait_state(3, 400, n);
    check_eq("glitch_requal", n, 256);

    // UP timeouts every 116 cycles
    channel_up = 1'b0; tick(); tick(); e_relink++;
    check_eq("to_rst", int'(state), 0);
    check_stats("to_pre");
    clear_all();
    wait_state(1, 50, n);
    check_eq("to_first_rst", n, 15);
    for (int i = 0; i < 3; i++) begin
      wait_state(0, 200, n);
      check_eq("to_waitup_len", n, 100);
      e_relink++;
      wait_state(1, 50, n);
      check_eq("to_rst_len", n, 16);
    end
    check_stats("to3");
    force_relink = 1'b1; tick(); force_relink = 1'b0; e_relink++;
    check_eq("force_waitup", int'(state), 0);
    check_stats("force_waitup");
    force_relink = 1'b1; tick(); force_relink = 1'b0;
    check_eq("force_rst_ignored", int'(state), 0);
    check_stats("force_rst");

    // Frame-error saturation and clear priority
    frame_error = 1'b1; repeat (20) tick(); frame_error = 1'b0; e_frame += 20;
    check_stats("frame_sat");
    frame_error = 1'b1; clear_stats = 1'b1; tick();
    frame_error = 1'b0; clear_stats = 1'b0;
    e_relink = 0; e_hard = 0; e_soft = 0; e_frame = 0;
    check_stats("clear_prio");

    // DRAIN_MAX bound with a stuck frame
    channel_up = 1'b1;
    wait_state(3, 400, n);
    tx_in_frame = 1'b1; force_relink = 1'b1; tick(); force_relink = 1'b0;
    check_eq("force_run_drain", int'(state), 4);
    wait_state(0, 100, n);
    check_eq("drain_max_len", n, 64);
    e_relink++;
    tx_in_frame = 1'b0;
    check_stats("drain_max");

    // Asynchronous reset from RUN
    wait_state(3, 400, n);
    check_eq("pre_async_bringup", n, 273);
    #3 reset = 1'b1;
    #1;
    check_eq("async_state", int'(state), 0);
    check_eq("async_link_reset", int'(link_reset), 1);
    check_eq("async_tx_enable", int'(tx_enable), 0);
    check_eq("async_link_ok", int'(link_ok), 0);
    e_relink = 0; e_hard = 0; e_soft = 0; e_frame = 0;
    check_stats("async");
    tick();
    reset = 1'b0;
    wait_state(1, 50, n);
    check_eq("async_rst_len", n, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aur_link_ctrl.md
Name: aur_link_ctrl

Overview:
Link-management controller for one Aurora serial port group. Sequences Aurora core reset and bring-up, and qualifies the channel as stable before traffic is allowed. Gates the TX/RX queues at frame boundaries, and forces a relink on hard errors, channel loss or excessive soft errors. Sits beside the Aurora core and the aur rx/tx queues inside the port group, in the user-clock domain.

Parameters:
RESET_CYCLES, 16, cycles link_reset is held high per reset attempt (min 2)
UP_TIMEOUT, 1048576, cycles to wait for channel_up before retrying reset
STABLE_CYCLES, 256, cycles channel_up and lane_up must stay high before RUN
SOFT_ERR_THRESH, 8, soft errors within one window that force a relink
SOFT_ERR_WINDOW, 65536, soft-error window length in cycles (free-running, restarts on entry to RUN)
DRAIN_MAX, 4096, max cycles to wait for an in-flight TX frame in DRAIN
CNT_WIDTH, 16, width of statistics counters

Ports:
clk  input  1  core user clock
reset  input  1  asynchronous, active-high
lane_up  input  1  Aurora lane status
channel_up  input  1  Aurora channel status
hard_error  input  1  Aurora hard error, 1-cycle pulse or level
soft_error  input  1  Aurora soft error, counted per cycle high
frame_error  input  1  Aurora frame error, counted per cycle high
tx_in_frame  input  1  tx queue is between SOF and EOF of a frame
force_relink  input  1  1-cycle software request to relink
clear_stats  input  1  1-cycle pulse: zero all statistics counters
link_reset  output  1  drives Aurora core RESET
tx_enable  output  1  tx queue may start a new frame
rx_enable  output  1  rx queue may accept data
link_ok  output  1  high only in RUN
state  output  3  current FSM state encoding
relink_count  output  CNT_WIDTH  relinks since clear, saturating
hard_err_count  output  CNT_WIDTH  hard errors, saturating
soft_err_count  output  CNT_WIDTH  soft errors, saturating
frame_err_count  output  CNT_WIDTH  frame errors, saturating

Behaviour:
- Reset values: state=RST(0), link_reset=1, tx_enable=0, rx_enable=0, link_ok=0, all counters 0.
- RST(0): link_reset=1. After RESET_CYCLES cycles -> WAIT_UP.
- WAIT_UP(1): link_reset=0. channel_up&&lane_up -> STABLE. Timeout after UP_TIMEOUT cycles -> RST, relink_count+1.
- STABLE(2): count consecutive cycles of channel_up&&lane_up. Any drop -> WAIT_UP, with no relink increment. Reaching STABLE_CYCLES -> RUN.
- RUN(3): tx_enable=1, rx_enable=1, link_ok=1. Any of the following -> DRAIN:
  - hard_error
  - !channel_up
  - force_relink
  - soft errors in the current window reaching SOFT_ERR_THRESH
- DRAIN(4): tx_enable=0 and link_ok=0 on the same clock edge as entry; rx_enable=0. When tx_in_frame=0 or DRAIN_MAX cycles elapse -> RST, relink_count+1.
- Outputs are registered: state change and the outputs for the new state appear in the same cycle.
- Priority in RUN, highest first: hard_error > !channel_up > force_relink > soft threshold. All of them lead to DRAIN, so the order matters only for debug.
- force_relink outside RUN:
  - In WAIT_UP or STABLE -> RST, relink_count+1.
  - In RST or DRAIN: ignored.
- Soft-error window:
  - Counter resets when the window expires and on RUN entry.
  - Soft errors outside RUN are counted in stats but not toward the threshold.
- Counters:
  - Saturate at all-ones; no wrap.
  - clear_stats has priority over a simultaneous increment: result is 0.
  - hard/soft/frame error counters increment in every state.
- Asynchronous reset mid-operation returns immediately to RST values. The core is held in reset for a full RESET_CYCLES after deassertion.

Optional Feature:
AUR_LINK_STATS_EN:
- Defined: the four statistics counters and clear_stats are implemented as above.
- Undefined: counter outputs are tied to 0 and clear_stats is ignored. The FSM, soft-error window and threshold logic are unchanged.

Test Plan:
- Reset release, channel_up and lane_up high at cycle 20 -> link_reset high 16 cycles; RUN (state=3, tx_enable=1) exactly 256 cycles after channel_up seen in WAIT_UP.
- channel_up never asserts (UP_TIMEOUT=100 in bench) -> RST re-entered every 116 cycles; relink_count=3 after 3 timeouts.
- In RUN with tx_in_frame=1, pulse hard_error -> DRAIN, tx_enable=0 next edge. Drop tx_in_frame 10 cycles later -> RST; relink_count+1; hard_err_count=1.
- In RUN, 8 soft_error pulses within 1000 cycles -> DRAIN. 7 pulses, then window expiry, then 7 more -> stays in RUN; soft_err_count=14.
- channel_up glitches low for 1 cycle at STABLE count 200 -> back to WAIT_UP; relink_count unchanged; full 256-cycle requalification required.
- Counter preloaded near saturation (CNT_WIDTH=4 bench), 20 frame_error cycles -> frame_err_count=15. clear_stats coincident with frame_error -> 0. Build without AUR_LINK_STATS_EN -> counter outputs read 0 throughout.
